// File: rtl/ifid_stage.sv
// IF/ID pipeline register with load-use stall detection and post-redirect squash window.
// Optional IFID_PERF_COUNTERS_EN adds saturating stall/flush event counters.
module ifid_stage #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iPC,
  input  logic [31:0] iIR,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_write_addr,
  input  logic        redirect,
  output logic [31:0] oPC,
  output logic [31:0] oIR,
  output logic        ovalid,
  output logic        pc_write,
  output logic        bubble,
`ifdef IFID_PERF_COUNTERS_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
`endif
  output logic        flush_active
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES) + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_ir;
  logic          r_valid;
  logic [CW-1:0] r_flush_cnt;

  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic          w_hazard;
  logic          w_squash;

  always_comb begin
    w_rs     = r_ir[25:21];
    w_rt     = r_ir[20:16];
    // Squashed slots and $0 destinations can never create a load-use dependency.
    w_hazard = r_valid & idex_mem_read & (idex_write_addr != 5'd0) &
               ((idex_write_addr == w_rs) | (idex_write_addr == w_rt));
    pc_write = ~w_hazard | redirect;
    bubble   = w_hazard & ~redirect;
    w_squash = redirect | (r_flush_cnt != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc        <= '0;
      r_ir        <= NOP_WORD;
      r_valid     <= 1'b0;
      r_flush_cnt <= '0;
    end else if (redirect) begin
      r_pc        <= iPC;
      r_ir        <= NOP_WORD;
      r_valid     <= 1'b0;
      r_flush_cnt <= CW'(FLUSH_CYCLES - 1);
    end else if (r_flush_cnt != '0) begin
      r_pc        <= iPC;
      r_ir        <= NOP_WORD;
      r_valid     <= 1'b0;
      r_flush_cnt <= r_flush_cnt - 1'b1;
    end else if (!w_hazard) begin
      r_pc        <= iPC;
      r_ir        <= iIR;
      r_valid     <= 1'b1;
    end
  end

`ifdef IFID_PERF_COUNTERS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (bubble && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
      if (w_squash && (r_flush_count != '1)) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

  assign oPC          = r_pc;
  assign oIR          = r_ir;
  assign ovalid       = r_valid;
  assign flush_active = (r_flush_cnt != '0);

endmodule

// File: tb/tb_ifid_stage.sv
// Directed bench for ifid_stage: one instance with FLUSH_CYCLES=1, one with FLUSH_CYCLES=3,
// sharing all inputs.
module tb_ifid_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iPC;
  logic [31:0] iIR;
  logic        idex_mem_read;
  logic [4:0]  idex_write_addr;
  logic        redirect;

  logic [31:0] oPC1, oIR1, oPC3, oIR3;
  logic        ovalid1, pc_write1, bubble1, flush_active1;
  logic        ovalid3, pc_write3, bubble3, flush_active3;
`ifdef IFID_PERF_COUNTERS_EN
  logic [31:0] stall_count1, flush_count1, stall_count3, flush_count3;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  ifid_stage #(.FLUSH_CYCLES(1), .NOP_WORD(32'h00000000)) dut1 (
    .clock(clock), .reset(reset), .iPC(iPC), .iIR(iIR),
    .idex_mem_read(idex_mem_read), .idex_write_addr(idex_write_addr),
    .redirect(redirect), .oPC(oPC1), .oIR(oIR1), .ovalid(ovalid1),
    .pc_write(pc_write1), .bubble(bubble1),
`ifdef IFID_PERF_COUNTERS_EN
    .stall_count(stall_count1), .flush_count(flush_count1),
`endif
    .flush_active(flush_active1)
  );

  ifid_stage #(.FLUSH_CYCLES(3), .NOP_WORD(32'h00000000)) dut3 (
    .clock(clock), .reset(reset), .iPC(iPC), .iIR(iIR),
    .idex_mem_read(idex_mem_read), .idex_write_addr(idex_write_addr),
    .redirect(redirect), .oPC(oPC3), .oIR(oIR3), .ovalid(ovalid3),
    .pc_write(pc_write3), .bubble(bubble3),
`ifdef IFID_PERF_COUNTERS_EN
    .stall_count(stall_count3), .flush_count(flush_count3),
`endif
    .flush_active(flush_active3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; iPC = 32'h4; iIR = 32'h8C220004;
    idex_mem_read = 1'b0; idex_write_addr = 5'd0; redirect = 1'b0;

    // Reset held two cycles
    step(); step();
    check("rst_oIR", oIR1, 32'h0);
    check("rst_oPC", oPC1, 32'h0);
    check("rst_ovalid", {31'b0, ovalid1}, 32'h0);
    check("rst_flush_active", {31'b0, flush_active1}, 32'h0);
    check("rst_pc_write", {31'b0, pc_write1}, 32'h1);

    reset = 1'b1;
    step();
    check("post_rst_oIR", oIR1, 32'h8C220004);
    check("post_rst_oPC", oPC1, 32'h4);
    check("post_rst_ovalid", {31'b0, ovalid1}, 32'h1);

    // Load-use on rs: add $3,$2,$4 behind a load to $2
    iIR = 32'h00441820; iPC = 32'h8;
    step();
    check("add_oIR", oIR1, 32'h00441820);
    iIR = 32'h00A63820; iPC = 32'hC;
    idex_mem_read = 1'b1; idex_write_addr = 5'd2;
    #1;
    check("lu_rs_pc_write", {31'b0, pc_write1}, 32'h0);
    check("lu_rs_bubble", {31'b0, bubble1}, 32'h1);
    step();
    check("lu_hold_oIR", oIR1, 32'h00441820);
    check("lu_hold_oPC", oPC1, 32'h8);
    idex_mem_read = 1'b0;
    #1;
    check("lu_clear_pc_write", {31'b0, pc_write1}, 32'h1);
    check("lu_clear_bubble", {31'b0, bubble1}, 32'h0);
    step();
    check("lu_adv_oIR", oIR1, 32'h00A63820);
    check("lu_adv_oPC", oPC1, 32'hC);

    // rt match (add $7,$5,$6 with load to $6), then rd-only match
    idex_mem_read = 1'b1; idex_write_addr = 5'd6;
    #1;
    check("lu_rt_bubble", {31'b0, bubble1}, 32'h1);
    idex_write_addr = 5'd7;
    #1;
    check("rd_only_bubble", {31'b0, bubble1}, 32'h0);
    idex_mem_read = 1'b0;

    // $0 rule: add $8,$0,$4 with load "to" $0
    iIR = 32'h00044020; iPC = 32'h10;
    step();
    check("zero_oIR", oIR1, 32'h00044020);
    idex_mem_read = 1'b1; idex_write_addr = 5'd0;
    #1;
    check("zero_pc_write", {31'b0, pc_write1}, 32'h1);
    check("zero_bubble", {31'b0, bubble1}, 32'h0);

    // Redirect beats stall (load to $4 matches rt)
    idex_write_addr = 5'd4;
    #1;
    check("pre_redir_bubble", {31'b0, bubble1}, 32'h1);
    redirect = 1'b1; iPC = 32'h100; iIR = 32'h12345678;
    #1;
    check("redir_pc_write", {31'b0, pc_write1}, 32'h1);
    check("redir_bubble", {31'b0, bubble1}, 32'h0);
    step();
    check("redir_oIR", oIR1, 32'h0);
    check("redir_oPC", oPC1, 32'h100);
    check("redir_ovalid", {31'b0, ovalid1}, 32'h0);
    check("redir_flush_active1", {31'b0, flush_active1}, 32'h0);
    redirect = 1'b0;
    #1;
    check("squashed_no_bubble", {31'b0, bubble1}, 32'h0);
    idex_mem_read = 1'b0;
    iIR = 32'h8C630008; iPC = 32'h104;
    step();
    check("after_redir_oIR", oIR1, 32'h8C630008);
    check("after_redir_ovalid", {31'b0, ovalid1}, 32'h1);

    // FLUSH_CYCLES=3 window from a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1; iIR = 32'h01010101; iPC = 32'h1F0;
    step();
    check("f3_pre_oIR", oIR3, 32'h01010101);
    redirect = 1'b1; iPC = 32'h200; iIR = 32'h11111111;
    step();
    check("f3_e1_oIR", oIR3, 32'h0);
    check("f3_e1_oPC", oPC3, 32'h200);
    check("f3_e1_flush_active", {31'b0, flush_active3}, 32'h1);
    redirect = 1'b0; iPC = 32'h204; iIR = 32'h22222222;
    step();
    check("f3_e2_oIR", oIR3, 32'h0);
    check("f3_e2_oPC", oPC3, 32'h204);
    check("f3_e2_ovalid", {31'b0, ovalid3}, 32'h0);
    check("f3_e2_flush_active", {31'b0, flush_active3}, 32'h1);
    check("f1_e2_oIR", oIR1, 32'h22222222);
    iPC = 32'h208; iIR = 32'h33333333;
    step();
    check("f3_e3_oIR", oIR3, 32'h0);
    check("f3_e3_flush_active", {31'b0, flush_active3}, 32'h0);
    iPC = 32'h20C; iIR = 32'h44444444;
    step();
    check("f3_pass_oIR", oIR3, 32'h44444444);
    check("f3_pass_ovalid", {31'b0, ovalid3}, 32'h1);

    // Redirect during an active window reloads the counter (not additive)
    redirect = 1'b1; iIR = 32'h55555555;
    step();
    step();
    check("f3_reload_active", {31'b0, flush_active3}, 32'h1);
    redirect = 1'b0; iIR = 32'h66666666;
    step();
    check("f3_reload_cnt1_oIR", oIR3, 32'h0);
    step();
    check("f3_reload_cnt1_active", {31'b0, flush_active3}, 32'h0);
    step();
    check("f3_reload_done_oIR", oIR3, 32'h66666666);

`ifdef IFID_PERF_COUNTERS_EN
    reset = 1'b0;
    step();
    reset = 1'b1; iIR = 32'h00441820;
    step();
    check("perf_rst_stall", stall_count1, 32'h0);
    idex_mem_read = 1'b1; idex_write_addr = 5'd2;
    step(); step();
    idex_mem_read = 1'b0; redirect = 1'b1;
    step();
    redirect = 1'b0;
    step();
    check("perf_stall_count", stall_count1, 32'd2);
    check("perf_flush_count", flush_count1, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
IF/ID pipeline register for the 5-stage MIPS32 pipeline, plus the front-end hazard control that feeds the ID/EX register.
- Latches fetched PC+4 and instruction every cycle.
- Detects load-use hazards against the instruction currently in EX, and stalls.
- Squashes wrong-path instructions for FLUSH_CYCLES cycles after a taken branch or jump.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles oIR is forced to NOP after a redirect (1..3)
NOP_WORD, 32'h00000000, instruction word inserted on flush/reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low; reset==0 on a rising edge resets the block
iPC  input  32  PC+4 from fetch
iIR  input  32  instruction from instruction memory
idex_mem_read  input  1  instruction in EX is a load
idex_write_addr  input  5  destination register of instruction in EX
redirect  input  1  branch taken or jump resolved this cycle
oPC  output  32  registered PC+4 to ID
oIR  output  32  registered instruction to ID
ovalid  output  1  oIR holds a real (non-squashed) instruction
pc_write  output  1  0 = fetch must hold PC this cycle
bubble  output  1  1 = ID must zero all control inputs of ID/EX this cycle
flush_active  output  1  a flush window is in progress

Behaviour:
- Reset (reset==0 at posedge): oPC=0, oIR=NOP_WORD, ovalid=0, flush counter=0. Reset overrides stall and redirect.
- Hazard detect (combinational, from current oIR):
  - rs=oIR[25:21], rt=oIR[20:16].
  - hazard = ovalid & idex_mem_read & (idex_write_addr!=0) & (idex_write_addr==rs | idex_write_addr==rt).
  - pc_write = ~hazard | redirect.
  - bubble = hazard & ~redirect.
- Register update at posedge, when reset==1, in priority order:
  1. redirect==1: oIR<=NOP_WORD, ovalid<=0, oPC<=iPC, flush counter<=FLUSH_CYCLES-1. Redirect beats stall.
  2. Flush counter != 0: oIR<=NOP_WORD, ovalid<=0, oPC<=iPC, counter decrements by 1.
  3. hazard==1: oPC, oIR and ovalid hold. Exactly one bubble cycle is inserted, because next cycle the load has left EX.
  4. Otherwise: oPC<=iPC, oIR<=iIR, ovalid<=1.
- flush_active = (flush counter != 0). With FLUSH_CYCLES=1 the counter stays 0; the redirect cycle alone squashes.
- Counter width: clog2(FLUSH_CYCLES)+1 bits.
- A redirect during an active flush window reloads the counter to FLUSH_CYCLES-1; the window is not extended additively.
- Latency: iIR appears on oIR one cycle after it is presented, absent stall or flush.
- Register $0 never causes a hazard.
- A squashed instruction (ovalid=0) never causes a hazard, even if its field bits match.

Optional Feature:
IFID_PERF_COUNTERS_EN:
- Defined: adds outputs stall_count[31:0] and flush_count[31:0].
  - stall_count increments on each cycle with bubble==1.
  - flush_count increments on each cycle oIR is loaded with NOP_WORD due to redirect or flush counter.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with iIR=32'h8C220004 -> oIR=0, oPC=0, ovalid=0. After reset=1, next edge -> oIR=32'h8C220004, ovalid=1.
- Load-use: oIR=add $3,$2,$4 (32'h00441820), idex_mem_read=1, idex_write_addr=2 -> pc_write=0, bubble=1, oIR unchanged for 1 edge. Then idex_mem_read=0 -> normal advance.
- $0 rule: same setup with idex_write_addr=0 and rs=0 -> no stall, pc_write=1, bubble=0.
- Redirect over stall: hazard and redirect=1 same cycle -> pc_write=1, bubble=0. Next edge oIR=0, ovalid=0, oPC=iPC.
- FLUSH_CYCLES=3: one-cycle redirect pulse -> oIR=NOP for 3 consecutive edges with flush_active=1 on the 2nd/3rd. Then iIR passes through.
- IFID_PERF_COUNTERS_EN defined: 2 load-use stalls and 1 redirect (FLUSH_CYCLES=1) -> stall_count=2, flush_count=1. Preload stall_count near saturation -> holds at 32'hFFFFFFFF.
